// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock, with the
// round keys expanded on the fly.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  sample in/key and begin an encryption (honoured only when idle)
//   in     plaintext  [0:127]; bits [8i:8i+7] are byte i
//   key    cipher key [0:127]; same byte ordering
//   out    ciphertext [0:127]; registered, holds until the next completion
//   busy   high while an encryption is in progress
//   done   one-cycle pulse when out holds a new ciphertext
module aes_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] in,
  input  logic [0:127] key,
  output logic [0:127] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       st_q, st_d;
  logic [0:127] state_q, state_d;
  logic [0:127] rkey_q, rkey_d;
  logic [0:127] out_q, out_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [0:31]  tw;
  logic [0:127] rnd_key;
  logic [0:127] rnd_out;
  logic         last_rnd;

  assign last_rnd = (cnt_q == 4'd10);

  // ---- round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_q[8*i +: 8]);
  end

  // Row r of column c takes the byte of row r from column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // Next round key: RotWord moves bytes 13,14,15,12 of the previous key into
  // the temp word; Rcon only touches its leading byte.
  assign tw = {sbox(rkey_q[104 +: 8]) ^ rcon(cnt_q), sbox(rkey_q[112 +: 8]),
               sbox(rkey_q[120 +: 8]), sbox(rkey_q[96 +: 8])};
  assign rnd_key[0:31]   = rkey_q[0:31]   ^ tw;
  assign rnd_key[32:63]  = rkey_q[32:63]  ^ rnd_key[0:31];
  assign rnd_key[64:95]  = rkey_q[64:95]  ^ rnd_key[32:63];
  assign rnd_key[96:127] = rkey_q[96:127] ^ rnd_key[64:95];

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign rnd_out[8*i +: 8] = (last_rnd ? sr[i] : mc[i]) ^ rnd_key[8*i +: 8];
  end

  // ---- control / next-state
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          state_d = in ^ key;
          rkey_d  = key;
          cnt_d   = 4'd1;
          st_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = rnd_out;
        rkey_d  = rnd_key;
        cnt_d   = cnt_q + 4'd1;
        if (last_rnd) begin
          out_d  = rnd_out;
          done_d = 1'b1;
          cnt_d  = 4'd0;
          st_d   = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // ---- state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (st_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: directed and randomized bench for aes_top. Expected ciphertexts
// come from a byte-array AES-128 model whose S-box is built from the GF(2^8)
// inverse and the affine transform, plus the published FIPS-197 vectors.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [0:127] tin = '0;
  logic [0:127] tkey = '0;
  logic [0:127] tout;
  logic         busy;
  logic         done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] sbt [256];

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (tin),
    .key   (tkey),
    .out   (tout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] w [44][4];
    logic [7:0] tmp [4];
    logic [7:0] st [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = k[127-8*(4*i+j) -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbt[w[i-1][(j+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][b%4];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbt[st[b]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) st[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = st[4*c+j];
          st[4*c+0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          st[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          st[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          st[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*r + b/4][b%4];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Launch one encryption and wait (bounded) for done. With disturb set,
  // in/key/start are scrambled every busy cycle.
  task automatic run_op(input logic [127:0] pt, input logic [127:0] k,
                        input bit disturb, output int lat, output int dcyc);
    logic [127:0] held;
    tin = pt; tkey = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'd1);
    held = tout;
    lat = 0;
    while (1) begin
      if (disturb) begin
        tin = rnd128(); tkey = rnd128(); start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
      if (done || lat >= 20) break;
      chk("busy_during_run", 128'(busy), 128'd1);
      chk("out_held_during_run", tout, held);
    end
    start = 1'b0;
    dcyc = cyc;
    chk("latency", 128'(lat), 128'd10);
    chk("done_seen", 128'(done), 128'd1);
    chk("busy_at_done", 128'(busy), 128'd0);
  endtask

  task automatic chk_quiet(input string tag, input int n, input logic [127:0] held);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk({tag, "_no_done"}, 128'(seen), 128'd0);
    chk({tag, "_out_held"}, tout, held);
  endtask

  initial begin
    int lat, d1, d2;
    logic [127:0] pt, k;
    build_sbox();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", tout, 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 128'(busy), 128'd0);

    // all-zero block and key
    @(negedge clk);
    run_op('0, '0, 1'b0, lat, d1);
    chk("zero_ct_const", tout, Z_CT);
    chk("zero_ct_model", tout, aes_ref('0, '0));
    chk_quiet("zero", 3, Z_CT);

    // App. B followed back-to-back by App. C.1
    @(negedge clk);
    run_op(B_PT, B_KEY, 1'b0, lat, d1);
    chk("b_ct_const", tout, B_CT);
    chk("b_ct_model", tout, aes_ref(B_PT, B_KEY));
    run_op(C_PT, C_KEY, 1'b0, lat, d2);
    chk("c1_ct_const", tout, C_CT);
    chk("c1_ct_model", tout, aes_ref(C_PT, C_KEY));
    chk("b2b_gap", 128'(d2 - d1), 128'd11);
    chk_quiet("c1", 3, C_CT);

    // start and input changes while busy are ignored
    pt = rnd128(); k = rnd128();
    @(negedge clk);
    run_op(pt, k, 1'b1, lat, d1);
    chk("disturb_ct", tout, aes_ref(pt, k));
    chk_quiet("disturb", 4, aes_ref(pt, k));

    // reset in the middle of an encryption
    pt = rnd128(); k = rnd128();
    @(negedge clk);
    tin = pt; tkey = k; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_out", tout, 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    chk_quiet("abort", 15, 128'd0);
    @(negedge clk);
    run_op(pt, k, 1'b0, lat, d1);
    chk("after_abort_ct", tout, aes_ref(pt, k));

    // randomized runs, alternating gaps and back-to-back starts
    for (int n = 0; n < 6; n++) begin
      pt = rnd128(); k = rnd128();
      if (n % 2 == 0) @(negedge clk);
      run_op(pt, k, 1'b0, lat, d1);
      chk("rand_ct", tout, aes_ref(pt, k));
    end
    chk_quiet("final", 3, tout);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
